// File: rtl/mmul_res_unload_if.sv
// Word-stream port of the result unloader: one 16-bit word per valid/ready handshake.
interface mmul_res_unload_if;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/mmul_res_unload.sv
// Montgomery multiplier result unloader: captures 256 bits (parallel or LSB-first serial)
// and streams them out as sixteen 16-bit words, least-significant word first.
module mmul_res_unload (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [255:0]         din,
  input  logic                 ser_start,
  input  logic                 sh_en,
  input  logic                 sin,
  mmul_res_unload_if.master    out_if,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

  state_t       state_reg, state_next;
  logic [255:0] data_reg, data_next;
  logic [7:0]   bcnt_reg, bcnt_next;
  logic [3:0]   wcnt_reg, wcnt_next;
  logic         done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      bcnt_reg  <= '0;
      wcnt_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      bcnt_reg  <= bcnt_next;
      wcnt_reg  <= wcnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    bcnt_next  = bcnt_reg;
    wcnt_next  = wcnt_reg;
    done_next  = 1'b0;
    if (clr) begin
      state_next = IDLE;
      data_next  = '0;
      bcnt_next  = '0;
      wcnt_next  = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          // Parallel load takes precedence over starting a serial capture.
          if (load) begin
            data_next  = din;
            wcnt_next  = '0;
            state_next = SEND;
          end else if (ser_start) begin
            bcnt_next  = '0;
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          if (sh_en) begin
            data_next = {sin, data_reg[255:1]};
            bcnt_next = bcnt_reg + 8'd1;
            if (bcnt_reg == 8'd255) begin
              wcnt_next  = '0;
              state_next = SEND;
            end
          end
        end
        SEND: begin
          if (out_if.dout_ready) begin
            data_next = {16'h0000, data_reg[255:16]};
            wcnt_next = wcnt_reg + 4'd1;
            if (wcnt_reg == 4'd15) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // All outputs come straight from registers; dout_ready only affects the next state.
  assign out_if.dout       = data_reg[15:0];
  assign out_if.dout_valid = (state_reg == SEND);
  assign busy              = (state_reg != IDLE);
  assign done              = done_reg;

endmodule

// File: tb/tb_mmul_res_unload.sv
// Directed self-checking bench for mmul_res_unload; inputs change on the falling edge,
// outputs are sampled on the falling edge, the design acts on the rising edge.
module tb_mmul_res_unload;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         load;
  logic [255:0] din;
  logic         ser_start;
  logic         sh_en;
  logic         sin;
  logic         busy;
  logic         done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mmul_res_unload_if bus ();

  mmul_res_unload dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .din       (din),
    .ser_start (ser_start),
    .sh_en     (sh_en),
    .sin       (sin),
    .out_if    (bus.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_load(input logic [255:0] v);
    @(negedge clk);
    load = 1'b1;
    din  = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at a falling edge with the design in SEND. Collects 16 words with the given
  // dout_ready probability, then checks the done pulse. Optionally issues a new load in
  // the done cycle.
  task automatic unload_expect(input logic [255:0] v, input int pct,
                               input bit chain, input logic [255:0] cv);
    int          k       = 0;
    int          cyc     = 0;
    bit          stalled = 0;
    logic [15:0] prev    = '0;
    logic [15:0] expw;
    while (k < 16 && cyc < 2000) begin
      bus.dout_ready = ($urandom_range(99) < pct);
      chk("valid_in_send", {255'd0, bus.dout_valid}, 256'd1);
      chk("no_early_done", {255'd0, done}, 256'd0);
      if (stalled) chk("stall_stable", {240'd0, bus.dout}, {240'd0, prev});
      if (bus.dout_ready) begin
        expw = v[16*k +: 16];
        chk($sformatf("word%0d", k), {240'd0, bus.dout}, {240'd0, expw});
        k++;
        stalled = 0;
      end else begin
        stalled = 1;
        prev    = bus.dout;
      end
      @(negedge clk);
      cyc++;
    end
    if (k < 16) chk("unload_timeout", k, 16);
    bus.dout_ready = 1'b0;
    chk("end_valid", {255'd0, bus.dout_valid}, 256'd0);
    chk("end_busy",  {255'd0, busy}, 256'd0);
    chk("end_done",  {255'd0, done}, 256'd1);
    if (chain) begin
      load = 1'b1;
      din  = cv;
    end
    @(negedge clk);
    load = 1'b0;
    chk("done_one_cycle", {255'd0, done}, 256'd0);
  endtask

  logic [255:0] par_v, bp_v, pri_v, ab_v, ones_v, ser_v;

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; din = '0;
    ser_start = 1'b0; sh_en = 1'b0; sin = 1'b0; bus.dout_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      par_v[16*k +: 16] = 16'(k);
      bp_v [16*k +: 16] = 16'hA500 + 16'(k);
      pri_v[16*k +: 16] = 16'hC000 + 16'(k);
      ab_v [16*k +: 16] = 16'h0100 + 16'(k);
    end
    ones_v = '1;
    ser_v  = 256'h123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0;

    // Reset state
    #12;
    chk("rst_dout",  {240'd0, bus.dout}, 256'd0);
    chk("rst_valid", {255'd0, bus.dout_valid}, 256'd0);
    chk("rst_busy",  {255'd0, busy}, 256'd0);
    chk("rst_done",  {255'd0, done}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", {255'd0, bus.dout_valid}, 256'd0);

    // Parallel unload, ready held high, chained back-to-back load in the done cycle
    apply_load(par_v);
    unload_expect(par_v, 100, 1'b1, bp_v);

    // Backpressure on the chained load
    unload_expect(bp_v, 30, 1'b0, '0);

    // Serial capture with a 3-cycle sh_en gap at bcnt 100
    @(negedge clk);
    ser_start = 1'b1;
    @(negedge clk);
    ser_start = 1'b0;
    chk("cap_busy",  {255'd0, busy}, 256'd1);
    chk("cap_valid", {255'd0, bus.dout_valid}, 256'd0);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        repeat (3) begin
          sh_en = 1'b0;
          sin   = 1'($urandom);
          @(negedge clk);
        end
      end
      sh_en = 1'b1;
      sin   = ser_v[i];
      if (i == 255) chk("cap_valid_before_last", {255'd0, bus.dout_valid}, 256'd0);
      @(negedge clk);
    end
    sh_en = 1'b0;
    sin   = 1'b0;
    chk("ser_first_word", {240'd0, bus.dout}, 256'h0DEF0);
    unload_expect(ser_v, 100, 1'b0, '0);

    // Priority: load beats ser_start; loads during SEND are ignored
    @(negedge clk);
    load = 1'b1; ser_start = 1'b1; din = pri_v;
    @(negedge clk);
    din = ~pri_v;
    chk("pri_word0", {240'd0, bus.dout}, 256'hC000);
    @(negedge clk);
    chk("pri_hold", {240'd0, bus.dout}, 256'hC000);
    load = 1'b0; ser_start = 1'b0; din = '0;
    unload_expect(pri_v, 100, 1'b0, '0);

    // Abort after five accepted words
    apply_load(ab_v);
    bus.dout_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("ab_word5", {240'd0, bus.dout}, 256'h0105);
    bus.dout_ready = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ab_valid", {255'd0, bus.dout_valid}, 256'd0);
    chk("ab_busy",  {255'd0, busy}, 256'd0);
    chk("ab_done",  {255'd0, done}, 256'd0);
    chk("ab_dout",  {240'd0, bus.dout}, 256'd0);
    @(negedge clk);
    chk("ab_done_later", {255'd0, done}, 256'd0);
    apply_load(ones_v);
    unload_expect(ones_v, 100, 1'b0, '0);

    // Asynchronous reset at bcnt 128
    @(negedge clk);
    ser_start = 1'b1;
    @(negedge clk);
    ser_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      sh_en = 1'b1;
      sin   = 1'b1;
      @(negedge clk);
    end
    sh_en = 1'b0;
    chk("mid_busy", {255'd0, busy}, 256'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  {255'd0, busy}, 256'd0);
    chk("arst_valid", {255'd0, bus.dout_valid}, 256'd0);
    chk("arst_done",  {255'd0, done}, 256'd0);
    chk("arst_dout",  {240'd0, bus.dout}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {255'd0, busy}, 256'd0);
    apply_load(par_v);
    unload_expect(par_v, 100, 1'b0, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
